// File: rtl/decode_pkg.sv
// Shared constants and payload types for the wavefront instruction buffer.
package decode_pkg;
    localparam int unsigned NUM_WF  = 40;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned WFID_W  = 6;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned CAND_W  = WFID_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } instr_entry_t;

    // Round-robin successor of a wavefront id, wrapping at NUM_WF-1.
    function automatic logic [WFID_W-1:0] wf_next(input logic [WFID_W-1:0] w);
        return (w == WFID_W'(NUM_WF - 1)) ? '0 : w + WFID_W'(1);
    endfunction
endpackage

// File: rtl/wave_instr_buffer_if.sv
// Fetch write port and decode bus of the wavefront instruction buffer.
interface wave_instr_buffer_if;
    import decode_pkg::*;

    logic                fetch_wr_valid;
    logic [WFID_W-1:0]   fetch_wr_wfid;
    logic [INSTR_W-1:0]  fetch_wr_instr;
    logic [PC_W-1:0]     fetch_wr_pc;
    logic                wave_ins_half_rqd;
    logic [WFID_W-1:0]   wave_ins_half_wfid;
    logic                wave_instr_valid;
    logic [INSTR_W-1:0]  wave_instr;
    logic [PC_W-1:0]     wave_instr_pc;
    logic [WFID_W-1:0]   wave_wfid;

    modport slave (
        input  fetch_wr_valid, fetch_wr_wfid, fetch_wr_instr, fetch_wr_pc,
        input  wave_ins_half_rqd, wave_ins_half_wfid,
        output wave_instr_valid, wave_instr, wave_instr_pc, wave_wfid
    );

    modport master (
        output fetch_wr_valid, fetch_wr_wfid, fetch_wr_instr, fetch_wr_pc,
        output wave_ins_half_rqd, wave_ins_half_wfid,
        input  wave_instr_valid, wave_instr, wave_instr_pc, wave_wfid
    );
endinterface

// File: rtl/wf_dword_fifo.sv
// Per-wavefront dword FIFO; flush beats push, and push+pop is accepted when full.
module wf_dword_fifo
    import decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  instr_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output instr_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    instr_entry_t     mem_q [DEPTH];
    instr_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (cnt_q != '0);
    assign push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        mem_d  = mem_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
endmodule

// File: rtl/wave_instr_buffer.sv
// Per-wavefront instruction buffer: round-robin issue to decode with a
// priority second-dword path and per-wavefront flush.
module wave_instr_buffer
    import decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wave_instr_buffer_if.slave   bus,
    input  logic [NUM_WF-1:0]    fetch_done,
    input  logic [NUM_WF-1:0]    issue_wf_ready,
    input  logic                 flush_valid,
    input  logic [WFID_W-1:0]    flush_wfid,
    output logic [NUM_WF-1:0]    buf_full,
    output logic                 err_overflow,
    output logic                 err_half_underflow
);
    instr_entry_t      push_data;
    instr_entry_t      head_a [NUM_WF];
    instr_entry_t      sel_entry;
    logic [CNT_W-1:0]  cnt_a  [NUM_WF];
    logic [NUM_WF-1:0] push_v, pop_v, flush_v, full_v, eligible;

    logic [WFID_W-1:0] rr_q, rr_d;
    logic [WFID_W-1:0] last_wf_q, last_wf_d;
    logic              last_wf_vld_q, last_wf_vld_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic              sel_valid;
    logic [WFID_W-1:0] sel_wf;
    logic              found;
    logic [WFID_W-1:0] winner;
    logic [CAND_W-1:0] cand;
    logic              half_hit;

    assign push_data = '{instr: bus.fetch_wr_instr, pc: bus.fetch_wr_pc};

    for (genvar w = 0; w < NUM_WF; w++) begin : g_wf
        assign push_v[w]  = bus.fetch_wr_valid && (bus.fetch_wr_wfid == WFID_W'(w));
        assign flush_v[w] = flush_valid && (flush_wfid == WFID_W'(w));
        assign eligible[w] = issue_wf_ready[w]
                          && ((cnt_a[w] >= CNT_W'(2)) || ((cnt_a[w] == CNT_W'(1)) && fetch_done[w]))
                          && !(last_wf_vld_q && (last_wf_q == WFID_W'(w)))
                          && !flush_v[w];

        wf_dword_fifo u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_v[w]),
            .push_data (push_data),
            .pop       (pop_v[w]),
            .flush     (flush_v[w]),
            .head      (head_a[w]),
            .count     (cnt_a[w]),
            .full      (full_v[w])
        );
    end

    // Half request wins outright; otherwise round-robin among eligible wavefronts.
    always_comb begin
        rr_d          = rr_q;
        last_wf_d     = last_wf_q;
        last_wf_vld_d = last_wf_vld_q;
        err_ovf_d     = err_ovf_q;
        err_unf_d     = err_unf_q;
        pop_v         = '0;
        sel_valid     = 1'b0;
        sel_wf        = '0;
        found         = 1'b0;
        winner        = '0;
        cand          = '0;
        half_hit      = (bus.wave_ins_half_wfid < WFID_W'(NUM_WF))
                     && !(flush_valid && (flush_wfid == bus.wave_ins_half_wfid));

        for (int i = 0; i < NUM_WF; i++) begin
            cand = {1'b0, rr_q} + CAND_W'(i);
            if (cand >= CAND_W'(NUM_WF)) begin
                cand = cand - CAND_W'(NUM_WF);
            end
            if (!found && eligible[cand[WFID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[WFID_W-1:0];
            end
        end

        if (bus.wave_ins_half_rqd) begin
            last_wf_vld_d = 1'b0;
            if (half_hit) begin
                if (cnt_a[bus.wave_ins_half_wfid] != '0) begin
                    pop_v[bus.wave_ins_half_wfid] = 1'b1;
                    sel_valid = 1'b1;
                    sel_wf    = bus.wave_ins_half_wfid;
                end else begin
                    err_unf_d = 1'b1;
                end
            end
        end else if (found) begin
            pop_v[winner] = 1'b1;
            sel_valid     = 1'b1;
            sel_wf        = winner;
            rr_d          = wf_next(winner);
            last_wf_d     = winner;
            last_wf_vld_d = 1'b1;
        end else begin
            last_wf_vld_d = 1'b0;
        end

        if (|(push_v & full_v & ~pop_v & ~flush_v)) begin
            err_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q          <= '0;
            last_wf_q     <= '0;
            last_wf_vld_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            last_wf_q     <= last_wf_d;
            last_wf_vld_q <= last_wf_vld_d;
            err_ovf_q     <= err_ovf_d;
            err_unf_q     <= err_unf_d;
        end
    end

    // Decode registers these, so they are driven straight from the selected head.
    assign sel_entry            = head_a[sel_wf];
    assign bus.wave_instr_valid = sel_valid;
    assign bus.wave_instr       = sel_valid ? sel_entry.instr : '0;
    assign bus.wave_instr_pc    = sel_valid ? sel_entry.pc    : '0;
    assign bus.wave_wfid        = sel_valid ? sel_wf          : '0;

    assign buf_full           = full_v;
    assign err_overflow       = err_ovf_q;
    assign err_half_underflow = err_unf_q;
endmodule

// File: tb/tb_wave_instr_buffer.sv
// Directed bench for wave_instr_buffer with a queue-based reference model.
module tb_wave_instr_buffer;
    import decode_pkg::*;

    localparam int NW = NUM_WF;
    localparam int DP = DEPTH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_WF-1:0] fetch_done;
    logic [NUM_WF-1:0] issue_wf_ready;
    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;
    logic [NUM_WF-1:0] buf_full;
    logic              err_overflow;
    logic              err_half_underflow;

    wave_instr_buffer_if bus();

    wave_instr_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .fetch_done         (fetch_done),
        .issue_wf_ready     (issue_wf_ready),
        .flush_valid        (flush_valid),
        .flush_wfid         (flush_wfid),
        .buf_full           (buf_full),
        .err_overflow       (err_overflow),
        .err_half_underflow (err_half_underflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one queue of {instr,pc} per wavefront plus RR/last bookkeeping.
    logic [63:0] mq [NW][$];
    int          m_rr;
    int          m_last;
    bit          m_ovf;
    bit          m_unf;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) mq[w].delete();
        m_rr   = 0;
        m_last = -1;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_cycle();
        int                hw;
        int                fw;
        int                ww;
        bit                fl;
        bit                ev;
        int                ew;
        logic [63:0]       ee;
        logic [NUM_WF-1:0] efull;
        hw = int'(bus.wave_ins_half_wfid);
        fw = int'(flush_wfid);
        ww = int'(bus.fetch_wr_wfid);
        fl = flush_valid && (fw < NW);
        ev = 1'b0;
        ew = 0;
        ee = '0;
        for (int w = 0; w < NW; w++) efull[WFID_W'(w)] = (mq[w].size() == DP);
        chk("buf_full", 64'(buf_full), 64'(efull));
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
        chk("err_half_underflow", 64'(err_half_underflow), 64'(m_unf));

        if (bus.wave_ins_half_rqd) begin
            m_last = -1;
            if (hw < NW && !(fl && fw == hw)) begin
                if (mq[hw].size() > 0) begin
                    ev = 1'b1;
                    ew = hw;
                    ee = mq[hw].pop_front();
                end else begin
                    m_unf = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                int w;
                w = (m_rr + i) % NW;
                if (!ev && issue_wf_ready[WFID_W'(w)]
                    && (mq[w].size() >= 2 || (mq[w].size() == 1 && fetch_done[WFID_W'(w)]))
                    && w != m_last && !(fl && fw == w)) begin
                    ev = 1'b1;
                    ew = w;
                end
            end
            if (ev) begin
                ee     = mq[ew].pop_front();
                m_rr   = (ew + 1) % NW;
                m_last = ew;
            end else begin
                m_last = -1;
            end
        end

        chk("valid", 64'(bus.wave_instr_valid), 64'(ev));
        chk("wfid", 64'(bus.wave_wfid), 64'(ev ? ew : 0));
        chk("instr", 64'(bus.wave_instr), 64'(ee[63:32]));
        chk("pc", 64'(bus.wave_instr_pc), 64'(ee[31:0]));

        if (fl) mq[fw].delete();
        if (bus.fetch_wr_valid && ww < NW && !(fl && fw == ww)) begin
            if (mq[ww].size() < DP) mq[ww].push_back({bus.fetch_wr_instr, bus.fetch_wr_pc});
            else m_ovf = 1'b1;
        end
    endtask

    // Compare process: inputs are stable mid-cycle, state advances at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
            chk("rst_valid", 64'(bus.wave_instr_valid), 64'd0);
            chk("rst_buf_full", 64'(buf_full), 64'd0);
        end else begin
            model_cycle();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int w, input logic [31:0] ins, input logic [31:0] pc);
        bus.fetch_wr_valid = 1'b1;
        bus.fetch_wr_wfid  = WFID_W'(w);
        bus.fetch_wr_instr = ins;
        bus.fetch_wr_pc    = pc;
        tick();
        bus.fetch_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int          rr_order [6] = '{0, 1, 39, 0, 1, 39};
    logic [31:0] rr_instr [6] = '{32'hC000_0000, 32'hC000_0100, 32'hC000_2700,
                                  32'hC000_0001, 32'hC000_0101, 32'hC000_2701};

    initial begin
        bus.fetch_wr_valid     = 1'b0;
        bus.fetch_wr_wfid      = '0;
        bus.fetch_wr_instr     = '0;
        bus.fetch_wr_pc        = '0;
        bus.wave_ins_half_rqd  = 1'b0;
        bus.wave_ins_half_wfid = '0;
        fetch_done             = '0;
        issue_wf_ready         = '0;
        flush_valid            = 1'b0;
        flush_wfid             = '0;
        do_reset();
        #1;
        chk("init_valid", 64'(bus.wave_instr_valid), 64'd0);
        chk("init_err_ovf", 64'(err_overflow), 64'd0);

        // Basic issue, then half request beating an eligible wf5.
        wr(3, 32'hAAAA_0001, 32'h100);
        wr(3, 32'hAAAA_0002, 32'h104);
        wr(5, 32'hBBBB_0001, 32'h200);
        wr(5, 32'hBBBB_0002, 32'h204);
        issue_wf_ready[3] = 1'b1;
        issue_wf_ready[5] = 1'b1;
        #1;
        chk("t1_valid", 64'(bus.wave_instr_valid), 64'd1);
        chk("t1_wfid", 64'(bus.wave_wfid), 64'd3);
        chk("t1_instr", 64'(bus.wave_instr), 64'hAAAA_0001);
        chk("t1_pc", 64'(bus.wave_instr_pc), 64'h100);
        tick();
        bus.wave_ins_half_rqd  = 1'b1;
        bus.wave_ins_half_wfid = 6'd3;
        #1;
        chk("t2_half_wfid", 64'(bus.wave_wfid), 64'd3);
        chk("t2_half_instr", 64'(bus.wave_instr), 64'hAAAA_0002);
        chk("t2_half_pc", 64'(bus.wave_instr_pc), 64'h104);
        tick();
        bus.wave_ins_half_rqd = 1'b0;
        #1;
        chk("t2_wf5_wfid", 64'(bus.wave_wfid), 64'd5);
        chk("t2_wf5_instr", 64'(bus.wave_instr), 64'hBBBB_0001);
        tick();
        #1;
        chk("t2_idle", 64'(bus.wave_instr_valid), 64'd0);
        issue_wf_ready = '0;

        // Round-robin with wrap from 39 to 0, no back-to-back repeats.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wr(0,  32'hC000_0000 + 32'(k),        32'h1000 + 32'(4 * k));
            wr(1,  32'hC000_0100 + 32'(k),        32'h1010 + 32'(4 * k));
            wr(39, 32'hC000_2700 + 32'(k),        32'h1270 + 32'(4 * k));
        end
        fetch_done[0] = 1'b1; fetch_done[1] = 1'b1; fetch_done[39] = 1'b1;
        issue_wf_ready[0] = 1'b1; issue_wf_ready[1] = 1'b1; issue_wf_ready[39] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("rr_wfid", 64'(bus.wave_wfid), 64'(rr_order[j]));
            chk("rr_instr", 64'(bus.wave_instr), 64'(rr_instr[j]));
            tick();
        end
        #1;
        chk("rr_drained", 64'(bus.wave_instr_valid), 64'd0);
        issue_wf_ready = '0;
        fetch_done     = '0;
        tick();

        // fetch_done gating of a lone dword, then half-request underflow.
        wr(7, 32'h7777_0000, 32'h700);
        issue_wf_ready[7] = 1'b1;
        #1;
        chk("wf7_held", 64'(bus.wave_instr_valid), 64'd0);
        tick();
        #1;
        chk("wf7_held2", 64'(bus.wave_instr_valid), 64'd0);
        fetch_done[7] = 1'b1;
        #1;
        chk("wf7_wfid", 64'(bus.wave_wfid), 64'd7);
        chk("wf7_instr", 64'(bus.wave_instr), 64'h7777_0000);
        tick();
        issue_wf_ready = '0;
        fetch_done     = '0;
        bus.wave_ins_half_rqd  = 1'b1;
        bus.wave_ins_half_wfid = 6'd9;
        #1;
        chk("unf_valid", 64'(bus.wave_instr_valid), 64'd0);
        tick();
        bus.wave_ins_half_rqd = 1'b0;
        #1;
        chk("unf_set", 64'(err_half_underflow), 64'd1);
        tick();
        tick();
        chk("unf_sticky", 64'(err_half_underflow), 64'd1);

        // Full FIFO: push+pop is legal, push alone overflows, flush beats write.
        for (int k = 0; k < 4; k++) wr(2, 32'h2222_0000 + 32'(k), 32'h220 + 32'(4 * k));
        #1;
        chk("wf2_full", 64'(buf_full[2]), 64'd1);
        issue_wf_ready[2]  = 1'b1;
        bus.fetch_wr_valid = 1'b1;
        bus.fetch_wr_wfid  = 6'd2;
        bus.fetch_wr_instr = 32'h2222_0004;
        bus.fetch_wr_pc    = 32'h230;
        #1;
        chk("wf2_pop_wfid", 64'(bus.wave_wfid), 64'd2);
        chk("wf2_pop_instr", 64'(bus.wave_instr), 64'h2222_0000);
        tick();
        bus.fetch_wr_valid = 1'b0;
        issue_wf_ready     = '0;
        #1;
        chk("wf2_still_full", 64'(buf_full[2]), 64'd1);
        chk("wf2_no_ovf", 64'(err_overflow), 64'd0);
        wr(2, 32'h2222_0005, 32'h234);
        #1;
        chk("wf2_ovf", 64'(err_overflow), 64'd1);
        flush_valid        = 1'b1;
        flush_wfid         = 6'd2;
        bus.fetch_wr_valid = 1'b1;
        bus.fetch_wr_instr = 32'h2222_0006;
        tick();
        flush_valid        = 1'b0;
        bus.fetch_wr_valid = 1'b0;
        #1;
        chk("wf2_flushed", 64'(buf_full[2]), 64'd0);
        issue_wf_ready[2] = 1'b1;
        fetch_done[2]     = 1'b1;
        #1;
        chk("wf2_empty", 64'(bus.wave_instr_valid), 64'd0);
        tick();
        issue_wf_ready = '0;
        fetch_done     = '0;

        // Asynchronous reset in mid-traffic, then RR restarts from wf0.
        for (int k = 0; k < 4; k++) wr(10, 32'hA000_0000 + 32'(k), 32'hA00 + 32'(4 * k));
        wr(4, 32'h4000_0000, 32'h400);
        wr(4, 32'h4000_0001, 32'h404);
        issue_wf_ready[4] = 1'b1;
        #1;
        chk("pre_rst_valid", 64'(bus.wave_instr_valid), 64'd1);
        chk("pre_rst_full10", 64'(buf_full[10]), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.wave_instr_valid), 64'd0);
        chk("async_rst_full", 64'(buf_full), 64'd0);
        tick();
        tick();
        issue_wf_ready = '0;
        rst = 1'b1;
        wr(10, 32'hD000_0000, 32'hD00);
        wr(10, 32'hD000_0001, 32'hD04);
        wr(4,  32'hE000_0000, 32'hE00);
        wr(4,  32'hE000_0001, 32'hE04);
        issue_wf_ready[4]  = 1'b1;
        issue_wf_ready[10] = 1'b1;
        #1;
        chk("post_rst_wfid", 64'(bus.wave_wfid), 64'd4);
        chk("post_rst_instr", 64'(bus.wave_instr), 64'hE000_0000);
        tick();
        #1;
        chk("post_rst_wfid2", 64'(bus.wave_wfid), 64'd10);
        chk("post_rst_instr2", 64'(bus.wave_instr), 64'hD000_0000);
        tick();
        issue_wf_ready = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
